// File: rtl/spi_transaction_fsm_pkg.sv
// Shared SPI-slave constants: shift-register mode codes and transaction FSM state encodings.
package spi_transaction_fsm_pkg;

  localparam logic [1:0] SR_HOLD  = 2'b00;
  localparam logic [1:0] SR_LEFT  = 2'b01;
  localparam logic [1:0] SR_PLOAD = 2'b11;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    GET    = 4'd1,
    GOT    = 4'd2,
    READ1  = 4'd3,
    READ2  = 4'd4,
    READ3  = 4'd5,
    WRITE1 = 4'd6,
    WRITE2 = 4'd7,
    DONE   = 4'd8
  } state_t;

  // States that shift a byte and therefore count SCLK edges.
  function automatic logic isShiftState(state_t s);
    return (s == GET) || (s == WRITE1) || (s == READ3);
  endfunction

endpackage

// File: rtl/spi_transaction_fsm_bit_counter.sv
// Byte-phase bit counter: clear has priority over inc; done flags the BITS-th counted edge.
module spi_bit_counter #(
  parameter int BITS = 8
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  clear,
  input  logic                  inc,
  output logic [$clog2(BITS):0] count,
  output logic                  done
);

  localparam int CW = $clog2(BITS) + 1;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)    count <= '0;
    else if (clear) count <= '0;
    else if (inc)   count <= count + 1'b1;
  end

  assign done = inc && (count == CW'(BITS - 1));

endmodule

// File: rtl/spi_transaction_fsm.sv
// SPI-slave transaction controller: command byte {addr, rw} then one data byte.
// Optional idle-SCLK abort is compiled in with `define SPI_TIMEOUT_EN.
module spi_transaction_fsm
  import spi_transaction_fsm_pkg::*;
#(
  parameter int BITS           = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       csN,
  input  logic       sclkPosedge,
  input  logic       sclkNegedge,
  input  logic       rwBit,
  output logic [1:0] srMode,
  output logic       srShiftEn,
  output logic       addrWe,
  output logic       dmWe,
  output logic       misoBufe,
  output logic       busy,
  output logic       abort
);

  if (BITS < 2 || TIMEOUT_CYCLES < 2) begin : gParamCheck
    $error("spi_transaction_fsm: BITS and TIMEOUT_CYCLES must both be >= 2");
  end

  state_t                state, nextState;
  logic                  cntInc, cntClear, cntDone, timeout;
  logic [$clog2(BITS):0] bitCnt;

  // Only the edge type owned by the current state is counted; csN high freezes counting.
  assign cntInc   = !csN && ((state == READ3) ? sclkNegedge
                                              : (isShiftState(state) && sclkPosedge));
  assign cntClear = csN || (nextState != state);

  spi_bit_counter #(.BITS(BITS)) uBitCnt (
    .clk    (clk),
    .resetN (resetN),
    .clear  (cntClear),
    .inc    (cntInc),
    .count  (bitCnt),
    .done   (cntDone)
  );

`ifdef SPI_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES);
  logic [IW-1:0] idleCnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      idleCnt <= '0;
    else if (!isShiftState(state) || sclkPosedge || sclkNegedge || nextState != state)
      idleCnt <= '0;
    else
      idleCnt <= idleCnt + 1'b1;
  end

  assign timeout = !csN && isShiftState(state) && !sclkPosedge && !sclkNegedge &&
                   (idleCnt == IW'(TIMEOUT_CYCLES - 1));
  assign abort   = timeout;
`else
  assign timeout = 1'b0;
  assign abort   = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    srMode    = SR_HOLD;
    srShiftEn = 1'b0;
    addrWe    = 1'b0;
    dmWe      = 1'b0;
    misoBufe  = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: nextState = GET;
      GET: begin
        srMode    = SR_LEFT;
        srShiftEn = sclkPosedge;
        if (timeout)      nextState = DONE;
        else if (cntDone) nextState = GOT;
      end
      GOT: begin
        addrWe    = 1'b1;
        nextState = rwBit ? READ1 : WRITE1;
      end
      // READ1 waits out the synchronous memory read before the parallel load.
      READ1: nextState = READ2;
      READ2: begin
        srMode    = SR_PLOAD;
        srShiftEn = 1'b1;
        nextState = READ3;
      end
      READ3: begin
        misoBufe  = 1'b1;
        srMode    = SR_LEFT;
        srShiftEn = sclkNegedge;
        if (timeout || cntDone) nextState = DONE;
      end
      WRITE1: begin
        srMode    = SR_LEFT;
        srShiftEn = sclkPosedge;
        if (timeout)      nextState = DONE;
        else if (cntDone) nextState = WRITE2;
      end
      WRITE2: begin
        dmWe      = 1'b1;
        nextState = DONE;
      end
      DONE:    nextState = DONE;
      default: nextState = IDLE;
    endcase
    // Deselect ends the frame immediately and blocks any side effect this cycle.
    if (csN) begin
      nextState = IDLE;
      srShiftEn = 1'b0;
      addrWe    = 1'b0;
      dmWe      = 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_transaction_fsm.sv
// Bench for spi_transaction_fsm: vector table, directed frame sequences and random cycles
// compared against a frame-level reference model.
module tb_spi_transaction_fsm;
  import spi_transaction_fsm_pkg::*;

  localparam int BITS = 8;
  localparam int TMO  = 16;

  logic       clk = 1'b0;
  logic       resetN, csN, sclkPosedge, sclkNegedge, rwBit;
  logic [1:0] srMode;
  logic       srShiftEn, addrWe, dmWe, misoBufe, busy, abort;

  int nChecks = 0;
  int nPass   = 0;
  int dmCount = 0;

  spi_transaction_fsm #(.BITS(BITS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .resetN      (resetN),
    .csN         (csN),
    .sclkPosedge (sclkPosedge),
    .sclkNegedge (sclkNegedge),
    .rwBit       (rwBit),
    .srMode      (srMode),
    .srShiftEn   (srShiftEn),
    .addrWe      (addrWe),
    .dmWe        (dmWe),
    .misoBufe    (misoBufe),
    .busy        (busy),
    .abort       (abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (dmWe === 1'b1) dmCount++;

  // Output bundle: {srMode[1:0], srShiftEn, addrWe, dmWe, misoBufe, busy, abort}
  localparam logic [7:0] O_IDLE   = {SR_HOLD, 6'b000000};
  localparam logic [7:0] O_SHIFT  = {SR_LEFT, 6'b100010};
  localparam logic [7:0] O_LISTEN = {SR_LEFT, 6'b000010};
  localparam logic [7:0] O_GOT    = {SR_HOLD, 6'b010010};
  localparam logic [7:0] O_WR2    = {SR_HOLD, 6'b001010};
  localparam logic [7:0] O_DONE   = {SR_HOLD, 6'b000010};

  function automatic logic [7:0] outs();
    return {srMode, srShiftEn, addrWe, dmWe, misoBufe, busy, abort};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: where the frame is, how many owned edges it has seen, idle run length.
  typedef enum {mIdle, mCmd, mGot, mRd1, mRd2, mRdOut, mWrIn, mWrCommit, mDone} phase_t;
  phase_t ph      = mIdle;
  int     edges   = 0;
  int     idleRun = 0;

  task automatic modelCheck();
    logic [1:0] m;
    logic       sh, aw, dw, mb, bz, ab;
    bit         listening, anyEdge, myEdge;
    int         idleNow;
    phase_t     nxt;
    if (!resetN) begin
      chk("model-in-reset", outs(), O_IDLE);
      ph = mIdle; edges = 0; idleRun = 0;
      return;
    end
    listening = (ph == mCmd) || (ph == mWrIn) || (ph == mRdOut);
    anyEdge   = sclkPosedge || sclkNegedge;
    myEdge    = (ph == mRdOut) ? sclkNegedge : sclkPosedge;
    idleNow   = anyEdge ? 0 : idleRun + 1;
    ab        = 1'b0;
`ifdef SPI_TIMEOUT_EN
    ab = !csN && listening && (idleNow == TMO);
`endif
    if (listening)       m = SR_LEFT;
    else if (ph == mRd2) m = SR_PLOAD;
    else                 m = SR_HOLD;
    sh = !csN && ((listening && myEdge) || ph == mRd2);
    aw = !csN && (ph == mGot);
    dw = !csN && (ph == mWrCommit);
    mb = (ph == mRdOut);
    bz = (ph != mIdle);
    chk("model", outs(), {m, sh, aw, dw, mb, bz, ab});

    nxt = ph;
    if (csN)     nxt = mIdle;
    else if (ab) nxt = mDone;
    else begin
      case (ph)
        mIdle:     nxt = mCmd;
        mGot:      nxt = rwBit ? mRd1 : mWrIn;
        mRd1:      nxt = mRd2;
        mRd2:      nxt = mRdOut;
        mWrCommit: nxt = mDone;
        mCmd:      if (myEdge && edges + 1 == BITS) nxt = mGot;
        mWrIn:     if (myEdge && edges + 1 == BITS) nxt = mWrCommit;
        mRdOut:    if (myEdge && edges + 1 == BITS) nxt = mDone;
        default:   nxt = ph;
      endcase
    end
    if (csN || nxt != ph) begin
      edges = 0; idleRun = 0;
    end else begin
      if (listening && myEdge) edges++;
      idleRun = idleNow;
    end
    ph = nxt;
  endtask

  // One clock cycle: drive after the rising edge, check on the falling edge.
  task automatic step(input logic c, input logic p, input logic n, input logic r);
    @(posedge clk); #1;
    csN = c; sclkPosedge = p; sclkNegedge = n; rwBit = r;
    @(negedge clk);
    modelCheck();
  endtask

  typedef struct { logic cs; logic pe; logic ne; logic rw; logic [7:0] exp; } vec_t;
  vec_t tbl[$];

  task automatic addRows(input int cnt, input logic cs, input logic pe, input logic ne,
                         input logic rw, input logic [7:0] exp);
    vec_t v;
    v.cs = cs; v.pe = pe; v.ne = ne; v.rw = rw; v.exp = exp;
    repeat (cnt) tbl.push_back(v);
  endtask

  initial begin
    int dm0;
    int abortAt;
    resetN = 1'b0; csN = 1'b1; sclkPosedge = 1'b0; sclkNegedge = 1'b0; rwBit = 1'b0;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset-state", dut.state, IDLE);
    chk("reset-bitcnt", dut.bitCnt, 0);
    resetN = 1'b1;
    step(1, 0, 0, 0);
    chk("idle-after-reset", outs(), O_IDLE);

    // Write frame cmd 0x54 (rw=0), noise in GOT and DONE, deselect.
    addRows(1, 1, 0, 0, 0, O_IDLE);
    addRows(1, 0, 0, 0, 0, O_IDLE);
    addRows(3, 0, 1, 0, 0, O_SHIFT);
    addRows(1, 0, 0, 1, 0, O_LISTEN);
    addRows(1, 0, 1, 1, 0, O_SHIFT);
    addRows(4, 0, 1, 0, 0, O_SHIFT);
    addRows(1, 0, 1, 0, 0, O_GOT);
    addRows(8, 0, 1, 0, 1, O_SHIFT);
    addRows(1, 0, 0, 0, 0, O_WR2);
    addRows(3, 0, 1, 0, 0, O_DONE);
    addRows(1, 1, 0, 0, 0, O_DONE);
    addRows(1, 1, 0, 0, 0, O_IDLE);
    dm0 = dmCount;
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].cs, tbl[i].pe, tbl[i].ne, tbl[i].rw);
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end
    chk("write-dmWe-once", dmCount - dm0, 1);

    // Read frame cmd 0x55.
    dm0 = dmCount;
    step(0, 0, 0, 1);
    repeat (BITS) step(0, 1, 0, 1);
    step(0, 0, 0, 1); chk("read-got-addrWe", addrWe, 1);
    step(0, 0, 0, 0); chk("read1-hold", {srMode, srShiftEn, busy}, {SR_HOLD, 2'b01});
    step(0, 1, 0, 0); chk("read2-pload", {srMode, srShiftEn}, {SR_PLOAD, 1'b1});
    step(0, 1, 0, 0); chk("read3-posedge-ignored", {misoBufe, srShiftEn}, 2'b10);
    for (int i = 0; i < BITS; i++) begin
      step(0, 0, 1, 0);
      chk($sformatf("read3-neg%0d", i), {misoBufe, srShiftEn}, 2'b11);
    end
    step(0, 0, 0, 0); chk("read-done", {misoBufe, busy, srMode}, {2'b01, SR_HOLD});
    chk("read-no-dmWe", dmCount - dm0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0); chk("read-idle", busy, 0);

    // Deselect after 5 data bits, then a complete frame.
    dm0 = dmCount;
    step(0, 0, 0, 0);
    repeat (BITS) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0);
    step(1, 1, 0, 0); chk("abort-shift-suppressed", srShiftEn, 0);
    step(1, 0, 0, 0); chk("abort-idle", {busy, dut.state}, {1'b0, IDLE});
    chk("abort-bitcnt", dut.bitCnt, 0);
    chk("abort-no-dmWe", dmCount - dm0, 0);
    step(0, 0, 0, 0);
    repeat (BITS) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    repeat (BITS) step(0, 1, 0, 0);
    step(0, 0, 0, 0); chk("refill-dmWe", dmWe, 1);
    step(0, 0, 0, 0); chk("refill-done", dut.state, DONE);
    chk("refill-dmWe-once", dmCount - dm0, 1);
    step(1, 0, 0, 0);

    // Reset in the middle of READ3.
    step(0, 0, 0, 1);
    repeat (BITS) step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    repeat (3) step(0, 0, 1, 0);
    chk("pre-reset-miso", misoBufe, 1);
    #1 resetN = 1'b0; #1;
    chk("reset-async-outputs", outs(), O_IDLE);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    resetN = 1'b1;
    step(1, 0, 0, 0); chk("reset-release-idle", dut.state, IDLE);

    // SCLK stops after 3 command bits.
    step(0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    abortAt = -1;
    for (int i = 1; i <= 40; i++) begin
      step(0, 0, 0, 0);
      if (abort === 1'b1 && abortAt < 0) abortAt = i;
    end
`ifdef SPI_TIMEOUT_EN
    chk("timeout-abort-cycle", abortAt, TMO);
    chk("timeout-state-done", dut.state, DONE);
`else
    chk("no-timeout-abort", abortAt, -1);
    chk("no-timeout-stays-get", dut.state, GET);
`endif
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Random cycles against the model.
    for (int i = 0; i < 3000; i++) begin
      logic c, p, n;
      c = ($urandom_range(0, 99) < 2);
      p = ($urandom_range(0, 99) < 35);
      n = ($urandom_range(0, 99) < 35);
      step(c, p, n, 1'($urandom));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
